// File: rtl/freq_div_prog.sv
// Programmable clock divider: CLKDIV with near-50% duty plus a period-start TICK.
// A new divisor is applied only at a period boundary, so CLKDIV never glitches.
//
// Ports:
//   CLK     system clock, rising edge
//   RSTN    synchronous active-low reset
//   EN      divider enable; low forces phase 0 and both outputs low
//   DIV     requested divisor, captured (clamped to >= 2) when DIV_LD=1
//   DIV_LD  one-cycle load strobe
//   CLKDIV  divided clock, high for ceil(D/2), low for floor(D/2) cycles
//   TICK    one-cycle pulse on the first cycle of each CLKDIV period
//   PEND    a loaded divisor waits for the next period boundary
//   DIV_ACT divisor currently in effect
module freq_div_prog #(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 8
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             EN,
   input  logic [DIV_W-1:0] DIV,
   input  logic             DIV_LD,
   output logic             CLKDIV,
   output logic             TICK,
   output logic             PEND,
   output logic [DIV_W-1:0] DIV_ACT
);

   localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

   logic [DIV_W-1:0] phase_q, phase_d;
   logic [DIV_W-1:0] act_q, act_d;
   logic [DIV_W-1:0] pv_q, pv_d;
   logic             pend_q, pend_d;
   logic             run_q, run_d;
   logic             clkdiv_q, clkdiv_d;
   logic             tick_q, tick_d;
   logic [DIV_W-1:0] div_c;
   logic [DIV_W:0]   half;
   logic             wrap;

   always_comb begin
      div_c   = (DIV < TWO) ? TWO : DIV;
      wrap    = run_q && (phase_q == act_q - ONE);
      phase_d = phase_q;
      act_d   = act_q;
      pv_d    = pv_q;
      pend_d  = pend_q;
      run_d   = run_q;
      if (!EN) begin
         // Idle: a load or a waiting value applies at once.
         phase_d = '0;
         run_d   = 1'b0;
         pend_d  = 1'b0;
         if (DIV_LD) begin
            act_d = div_c;
            pv_d  = div_c;
         end else if (pend_q) begin
            act_d = pv_q;
         end
      end else if (!run_q || wrap) begin
         // Period start: the only point where the divisor may change.
         phase_d = '0;
         run_d   = 1'b1;
         pend_d  = 1'b0;
         if (DIV_LD) begin
            act_d = div_c;
            pv_d  = div_c;
         end else if (pend_q) begin
            act_d = pv_q;
         end
      end else begin
         phase_d = phase_q + ONE;
         if (DIV_LD) begin
            pv_d   = div_c;
            pend_d = 1'b1;
         end
      end
      // Extra bit so D = 2^DIV_W-1 does not overflow when rounding up.
      half     = ({1'b0, act_d} + (DIV_W+1)'(1)) >> 1;
      clkdiv_d = EN && ({1'b0, phase_d} < half);
      tick_d   = EN && (phase_d == '0);
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         phase_q  <= '0;
         act_q    <= DEF;
         pv_q     <= DEF;
         pend_q   <= 1'b0;
         run_q    <= 1'b0;
         clkdiv_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         act_q    <= act_d;
         pv_q     <= pv_d;
         pend_q   <= pend_d;
         run_q    <= run_d;
         clkdiv_q <= clkdiv_d;
         tick_q   <= tick_d;
      end
   end

   assign CLKDIV  = clkdiv_q;
   assign TICK    = tick_q;
   assign PEND    = pend_q;
   assign DIV_ACT = act_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// Bench for freq_div_prog: cycle model feeds a scoreboard queue,
// each scenario task pops and compares after every edge.
module tb_freq_div_prog;

   logic       CLK = 1'b0;
   logic       RSTN = 1'b0;
   logic       EN = 1'b0;
   logic [7:0] DIV = '0;
   logic       DIV_LD = 1'b0;
   logic       CLKDIV, TICK, PEND;
   logic [7:0] DIV_ACT;

   freq_div_prog #(.DIV_W(8), .DEF_DIV(8)) dut (
      .CLK(CLK), .RSTN(RSTN), .EN(EN), .DIV(DIV), .DIV_LD(DIV_LD),
      .CLKDIV(CLKDIV), .TICK(TICK), .PEND(PEND), .DIV_ACT(DIV_ACT)
   );

   always #5 CLK = ~CLK;

   logic [10:0] obs;
   assign obs = {CLKDIV, TICK, PEND, DIV_ACT};

   logic [10:0] sb[$];
   logic [10:0] e;
   int n_run = 0;
   int n_fail = 0;

   int m_p = 0, m_d = 8, m_pv = 8;
   bit m_pend = 0, m_run = 0;

   // Drive one cycle, advance the model, queue the expected outputs.
   task automatic cyc(input bit en, input bit ld, input int dv, input bit rn);
      int c;
      bit ck, tk;
      EN = en; DIV_LD = ld; DIV = 8'(dv); RSTN = rn;
      c = (dv < 2) ? 2 : dv;
      ck = 0; tk = 0;
      if (!rn) begin
         m_p = 0; m_d = 8; m_pv = 8; m_pend = 0; m_run = 0;
      end else if (!en) begin
         if (ld) m_d = c;
         else if (m_pend) m_d = m_pv;
         m_pend = 0; m_p = 0; m_run = 0;
      end else begin
         if (!m_run || m_p == m_d - 1) begin
            if (ld) m_d = c;
            else if (m_pend) m_d = m_pv;
            m_pend = 0; m_p = 0; m_run = 1;
         end else begin
            if (ld) begin m_pv = c; m_pend = 1; end
            m_p++;
         end
         ck = (2 * m_p < m_d);
         tk = (m_p == 0);
      end
      sb.push_back({ck, tk, m_pend, 8'(m_d)});
      @(posedge CLK); #1;
   endtask

   task automatic test_reset;
      int ticks = 0, highs = 0;
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 0, 0);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL reset got %h want %h", obs, e); end
      end
      n_run++;
      if (DIV_ACT !== 8'd8 || CLKDIV !== 0) begin
         n_fail++; $display("FAIL reset_div got %0d want 8", DIV_ACT);
      end
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL idle got %h want %h", obs, e); end
      end
      for (int i = 0; i < 200; i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL div8 cyc %0d got %h want %h", i, obs, e); end
         if (i == 0) begin
            n_run++;
            if (TICK !== 1 || CLKDIV !== 1) begin
               n_fail++; $display("FAIL first_tick got %b%b want 11", TICK, CLKDIV);
            end
         end
         ticks += TICK; highs += CLKDIV;
      end
      n_run++;
      if (ticks != 25 || highs != 100) begin
         n_fail++; $display("FAIL div8_count got %0d/%0d want 25/100", ticks, highs);
      end
   endtask

   task automatic test_odd;
      int highs = 0, pends = 0;
      cyc(0, 1, 5, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL odd_ld got %h want %h", obs, e); end
      n_run++;
      if (DIV_ACT !== 8'd5 || PEND !== 0) begin
         n_fail++; $display("FAIL odd_act got %0d want 5", DIV_ACT);
      end
      for (int i = 0; i < 20; i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL odd got %h want %h", obs, e); end
         if (i < 5) highs += CLKDIV;
         pends += PEND;
      end
      n_run++;
      if (highs != 3 || pends != 0) begin
         n_fail++; $display("FAIL odd_duty got %0d/%0d want 3/0", highs, pends);
      end
   endtask

   task automatic test_on_the_fly;
      cyc(0, 1, 8, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL otf_ld got %h want %h", obs, e); end
      for (int i = 0; i < 20 && !(m_run && m_p == 2); i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL otf_pre got %h want %h", obs, e); end
      end
      cyc(1, 1, 3, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL otf_load got %h want %h", obs, e); end
      n_run++;
      if (PEND !== 1 || DIV_ACT !== 8'd8) begin
         n_fail++; $display("FAIL otf_pend got %b/%0d want 1/8", PEND, DIV_ACT);
      end
      for (int i = 0; i < 14; i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL otf got %h want %h", obs, e); end
      end
      n_run++;
      if (DIV_ACT !== 8'd3 || PEND !== 0) begin
         n_fail++; $display("FAIL otf_new got %0d want 3", DIV_ACT);
      end
   endtask

   task automatic test_clamp;
      int ticks = 0;
      cyc(0, 1, 8, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL cl_ld got %h want %h", obs, e); end
      for (int i = 0; i < 20 && !(m_run && m_p == 1); i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL cl_pre got %h want %h", obs, e); end
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1, i != 1, (i == 0) ? 0 : 1, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL cl_load got %h want %h", obs, e); end
      end
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL clamp got %h want %h", obs, e); end
      end
      n_run++;
      if (DIV_ACT !== 8'd2) begin
         n_fail++; $display("FAIL clamp_act got %0d want 2", DIV_ACT);
      end
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL d2 got %h want %h", obs, e); end
         ticks += TICK;
      end
      n_run++;
      if (ticks != 3) begin
         n_fail++; $display("FAIL d2_ticks got %0d want 3", ticks);
      end
   endtask

   task automatic test_boundary_load;
      cyc(0, 1, 8, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL bl_ld got %h want %h", obs, e); end
      for (int i = 0; i < 20 && !(m_run && m_p == 7); i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL bl_pre got %h want %h", obs, e); end
      end
      cyc(1, 1, 6, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL bl_load got %h want %h", obs, e); end
      n_run++;
      if (PEND !== 0 || DIV_ACT !== 8'd6 || TICK !== 1) begin
         n_fail++; $display("FAIL bl_act got %b/%0d want 0/6", PEND, DIV_ACT);
      end
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL d6 got %h want %h", obs, e); end
      end
   endtask

   task automatic test_en_rst;
      cyc(0, 1, 8, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL er_ld got %h want %h", obs, e); end
      for (int i = 0; i < 20 && !(m_run && m_p == 4); i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL er_pre got %h want %h", obs, e); end
      end
      cyc(0, 0, 0, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL er_off got %h want %h", obs, e); end
      n_run++;
      if (CLKDIV !== 0 || TICK !== 0) begin
         n_fail++; $display("FAIL en_low got %b%b want 00", CLKDIV, TICK);
      end
      cyc(1, 0, 0, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL er_on got %h want %h", obs, e); end
      n_run++;
      if (CLKDIV !== 1 || TICK !== 1) begin
         n_fail++; $display("FAIL restart got %b%b want 11", CLKDIV, TICK);
      end
      cyc(1, 0, 0, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL er_p1 got %h want %h", obs, e); end
      cyc(1, 1, 3, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL er_pend got %h want %h", obs, e); end
      cyc(1, 0, 0, 0);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL er_rst got %h want %h", obs, e); end
      n_run++;
      if (DIV_ACT !== 8'd8 || PEND !== 0 || CLKDIV !== 0) begin
         n_fail++; $display("FAIL mid_rst got %b/%0d want 0/8", PEND, DIV_ACT);
      end
   endtask

   task automatic test_max;
      int ticks = 0;
      cyc(0, 1, 255, 1);
      e = sb.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL max_ld got %h want %h", obs, e); end
      for (int i = 0; i < 300; i++) begin
         cyc(1, 0, 0, 1);
         e = sb.pop_front(); n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL max got %h want %h", obs, e); end
         ticks += TICK;
      end
      n_run++;
      if (ticks != 2) begin
         n_fail++; $display("FAIL max_ticks got %0d want 2", ticks);
      end
   endtask

   initial begin
      test_reset();
      test_odd();
      test_on_the_fly();
      test_clamp();
      test_boundary_load();
      test_en_rst();
      test_max();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
